// File: rtl/miniled_pkg.sv
// Shared MiniLED datapath constants and the frame shifter state encoding.
package miniled_pkg;

    localparam int N_LED  = 360;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        LATCH   = 2'd3
    } state_e;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one synchronous write port, one registered read port.
module frame_ram #(
    parameter int DEPTH = 360,
    parameter int WIDTH = 16,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the array and its read register carry no reset so they map onto
    // block RAM; stale contents are masked by the valid bitmap in the parent.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sdbp_frame_shifter.sv
// Captures one frame of LED brightness words from the write stream, then
// shifts it MSB-first to the driver chain and finishes with a latch pulse.
module sdbp_frame_shifter
    import miniled_pkg::*;
#(
    parameter int N_LED       = miniled_pkg::N_LED,
    parameter int DATA_W      = miniled_pkg::DATA_W,
    parameter int ADDR_W      = miniled_pkg::ADDR_W,
    parameter int SCLK_DIV    = 2,
    parameter int LATCH_CYC   = 4,
    parameter int CAP_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdbpflag,
    input  logic [ADDR_W-1:0] wtaddr,
    input  logic [DATA_W-1:0] wtdina,
    output logic              sclk,
    output logic              sdo,
    output logic              le,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic [ADDR_W-1:0] wr_count
);

    localparam int RAM_AW = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DIV_W  = $clog2(2 * SCLK_DIV);
    localparam int LAT_W  = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
    localparam int TMO_W  = (CAP_TIMEOUT > 1) ? $clog2(CAP_TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0] N_LED_A   = ADDR_W'(N_LED);
    localparam logic [RAM_AW-1:0] LAST_WORD = RAM_AW'(N_LED - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(SCLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * SCLK_DIV - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LATCH_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(CAP_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                flag_q, flag_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [N_LED-1:0]    valid_q, valid_d;
    logic [ADDR_W-1:0]   cap_cnt_q, cap_cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                ld_q, ld_d;
    logic [RAM_AW-1:0]   word_q, word_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                sclk_q, sclk_d;
    logic                sdo_q, sdo_d;
    logic                le_q, le_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic [ADDR_W-1:0]   wr_count_q, wr_count_d;
    logic                byp_q, byp_d;
    logic [DATA_W-1:0]   byp_data_q, byp_data_d;

    logic                rise;
    logic                wr_en;
    logic [RAM_AW-1:0]   wr_idx;
    logic [RAM_AW-1:0]   rd_addr;
    logic [RAM_AW-1:0]   nxt_idx;
    logic [DATA_W-1:0]   ram_rdata;
    logic [DATA_W-1:0]   rd_data;
    logic [DATA_W-1:0]   nxt_word;

    assign rise    = sdbpflag & ~flag_q;
    assign wr_en   = (state_q == CAPTURE) && (wtaddr != '0) && (wtaddr <= N_LED_A)
                     && (wtaddr != addr_q);
    assign wr_idx  = RAM_AW'(wtaddr - ADDR_W'(1));

    // Prefetch the following word while the current one is shifting out.
    assign rd_addr = (state_q == SHIFT && !ld_q && word_q != LAST_WORD)
                     ? word_q + RAM_AW'(1) : '0;

    // Word 0 is read in the last capture cycle, which may also be its write cycle.
    assign rd_data  = byp_q ? byp_data_q : ram_rdata;
    assign nxt_idx  = ld_q ? '0 : word_q + RAM_AW'(1);
    assign nxt_word = valid_q[nxt_idx] ? rd_data : '0;

    frame_ram #(
        .DEPTH (N_LED),
        .WIDTH (DATA_W),
        .AW    (RAM_AW)
    ) u_frame_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_idx),
        .wdata (wtdina),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // NOTE: every *_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        flag_d     = sdbpflag;
        addr_d     = wtaddr;
        valid_d    = valid_q;
        cap_cnt_d  = cap_cnt_q;
        tmo_d      = tmo_q;
        ld_d       = ld_q;
        word_d     = word_q;
        bit_d      = bit_q;
        div_d      = div_q;
        lat_d      = lat_q;
        shreg_d    = shreg_q;
        sclk_d     = sclk_q;
        sdo_d      = sdo_q;
        le_d       = le_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q | (rise && state_q != IDLE);
        wr_count_d = wr_count_q;
        byp_d      = wr_en && (wr_idx == rd_addr);
        byp_data_d = wtdina;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    valid_d   = '0;
                    cap_cnt_d = '0;
                    tmo_d     = '0;
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (wr_en) begin
                    valid_d[wr_idx] = 1'b1;
                    if (cap_cnt_q != N_LED_A) begin
                        cap_cnt_d = cap_cnt_q + ADDR_W'(1);
                    end
                end
                tmo_d = tmo_q + TMO_W'(1);
                if ((wtaddr == '0 && addr_q != '0) || tmo_q == TMO_LAST) begin
                    wr_count_d = cap_cnt_d;
                    ld_d       = 1'b1;
                    word_d     = '0;
                    bit_d      = '0;
                    div_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (ld_q) begin
                    ld_d    = 1'b0;
                    shreg_d = nxt_word;
                    sdo_d   = nxt_word[DATA_W-1];
                end else if (div_q != DIV_LAST) begin
                    div_d  = div_q + DIV_W'(1);
                    sclk_d = (div_q + DIV_W'(1)) >= DIV_HALF;
                end else begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q != LAST_BIT) begin
                        bit_d   = bit_q + BIT_W'(1);
                        shreg_d = shreg_q << 1;
                        sdo_d   = shreg_d[DATA_W-1];
                    end else if (word_q != LAST_WORD) begin
                        bit_d   = '0;
                        word_d  = word_q + RAM_AW'(1);
                        shreg_d = nxt_word;
                        sdo_d   = nxt_word[DATA_W-1];
                    end else begin
                        sdo_d   = 1'b0;
                        le_d    = 1'b1;
                        lat_d   = '0;
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                if (lat_q == LAT_LAST) begin
                    le_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            flag_q     <= 1'b0;
            addr_q     <= '0;
            valid_q    <= '0;
            cap_cnt_q  <= '0;
            tmo_q      <= '0;
            ld_q       <= 1'b0;
            word_q     <= '0;
            bit_q      <= '0;
            div_q      <= '0;
            lat_q      <= '0;
            shreg_q    <= '0;
            sclk_q     <= 1'b0;
            sdo_q      <= 1'b0;
            le_q       <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            wr_count_q <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            flag_q     <= flag_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            cap_cnt_q  <= cap_cnt_d;
            tmo_q      <= tmo_d;
            ld_q       <= ld_d;
            word_q     <= word_d;
            bit_q      <= bit_d;
            div_q      <= div_d;
            lat_q      <= lat_d;
            shreg_q    <= shreg_d;
            sclk_q     <= sclk_d;
            sdo_q      <= sdo_d;
            le_q       <= le_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            wr_count_q <= wr_count_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

    assign sclk       = sclk_q;
    assign sdo        = sdo_q;
    assign le         = le_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign overrun    = overrun_q;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_sdbp_frame_shifter.sv
// Directed bench for sdbp_frame_shifter: full, timeout/reset and sparse frames,
// with a serial monitor that reassembles words on sclk rising edges.
module tb_sdbp_frame_shifter;

    localparam int N_LED     = 360;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 10;
    localparam int FRAME_CYC = N_LED * DATA_W * 2 * 2 + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sdbpflag;
    logic [ADDR_W-1:0] wtaddr;
    logic [DATA_W-1:0] wtdina;
    logic              sclk;
    logic              sdo;
    logic              le;
    logic              busy;
    logic              frame_done;
    logic              overrun;
    logic [ADDR_W-1:0] wr_count;

    int checks = 0;
    int errors = 0;

    logic              mon_clr = 1'b0;
    logic              prev_sclk;
    logic [DATA_W-1:0] mon_sh;
    logic [DATA_W-1:0] words [0:N_LED-1];
    int                rise_cnt;
    int                bit_cnt;
    int                word_cnt;

    sdbp_frame_shifter #(
        .N_LED       (N_LED),
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .SCLK_DIV    (2),
        .LATCH_CYC   (4),
        .CAP_TIMEOUT (1024)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sdbpflag   (sdbpflag),
        .wtaddr     (wtaddr),
        .wtdina     (wtdina),
        .sclk       (sclk),
        .sdo        (sdo),
        .le         (le),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .wr_count   (wr_count)
    );

    always #20 clk = ~clk;

    // Serial receiver model: shift sdo in on every sclk rising edge.
    always @(negedge clk) begin
        if (mon_clr) begin
            prev_sclk <= 1'b0;
            mon_sh    <= '0;
            rise_cnt  <= 0;
            bit_cnt   <= 0;
            word_cnt  <= 0;
        end else begin
            prev_sclk <= sclk;
            if (sclk && !prev_sclk) begin
                rise_cnt <= rise_cnt + 1;
                mon_sh   <= {mon_sh[DATA_W-2:0], sdo};
                if (bit_cnt == DATA_W - 1) begin
                    bit_cnt <= 0;
                    if (word_cnt < N_LED) words[word_cnt] <= {mon_sh[DATA_W-2:0], sdo};
                    word_cnt <= word_cnt + 1;
                end else begin
                    bit_cnt <= bit_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n;
    int m;

    initial begin
        rst_n    = 1'b0;
        sdbpflag = 1'b0;
        wtaddr   = '0;
        wtdina   = '0;
        mon_clr  = 1'b1;
        repeat (3) tick();
        check("rst_sclk", 32'(sclk), 0);
        check("rst_sdo", 32'(sdo), 0);
        check("rst_le", 32'(le), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_wr_count", 32'(wr_count), 0);
        rst_n = 1'b1;
        tick();
        mon_clr = 1'b0;

        // Full frame: words 1..360, second flag pulse during SHIFT.
        sdbpflag = 1'b1;
        tick();
        sdbpflag = 1'b0;
        check("full_busy", 32'(busy), 1);
        for (int a = 1; a <= N_LED; a++) begin
            wtaddr = ADDR_W'(a);
            wtdina = DATA_W'(a);
            tick();
        end
        wtaddr = '0;
        tick();
        check("full_wr_count", 32'(wr_count), 360);
        check("full_overrun_pre", 32'(overrun), 0);
        n = 0;
        while (!le && n < FRAME_CYC + 100) begin
            sdbpflag = (n == 20);
            tick();
            n++;
        end
        sdbpflag = 1'b0;
        check("full_shift_cycles", 32'(n), 32'(FRAME_CYC));
        check("full_overrun", 32'(overrun), 1);
        check("full_sclk_rises", 32'(rise_cnt), 5760);
        check("full_word_cnt", 32'(word_cnt), 360);
        for (int i = 0; i < N_LED; i++) begin
            check($sformatf("full_word%0d", i), 32'(words[i]), 32'(i + 1));
        end
        m = 0;
        while (le && m < 10) begin
            check("full_latch_sclk", 32'(sclk), 0);
            tick();
            m++;
        end
        check("full_le_cycles", 32'(m), 4);
        check("full_frame_done", 32'(frame_done), 1);
        check("full_idle_busy", 32'(busy), 0);
        tick();
        check("full_done_pulse", 32'(frame_done), 0);
        check("full_no_new_capture", 32'(busy), 0);
        check("full_overrun_sticky", 32'(overrun), 1);

        // Timeout: address stuck at 5, SHIFT 1024 cycles after CAPTURE entry.
        sdbpflag = 1'b1;
        tick();
        sdbpflag = 1'b0;
        wtaddr   = 10'd5;
        wtdina   = 16'h1234;
        n = 0;
        while (!sclk && n < 2000) begin
            tick();
            n++;
        end
        check("tmo_first_sclk", 32'(n), 1027);
        check("tmo_wr_count", 32'(wr_count), 1);
        check("tmo_overrun_sticky", 32'(overrun), 1);

        // Reset while bit 100 is on the wire.
        repeat (400) tick();
        check("rst100_sclk_pre", 32'(sclk), 1);
        check("rst100_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst100_sclk", 32'(sclk), 0);
        check("rst100_sdo", 32'(sdo), 0);
        check("rst100_le", 32'(le), 0);
        check("rst100_busy", 32'(busy), 0);
        check("rst100_overrun", 32'(overrun), 0);
        check("rst100_wr_count", 32'(wr_count), 0);
        wtaddr = '0;
        repeat (3) tick();
        check("rst100_no_le", 32'(le), 0);
        rst_n   = 1'b1;
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        check("rst100_idle", 32'(busy), 0);

        // Sparse frame: out-of-range addresses, then address 24 held three cycles.
        sdbpflag = 1'b1;
        tick();
        sdbpflag = 1'b0;
        check("sparse_busy", 32'(busy), 1);
        wtaddr = 10'd361;
        wtdina = 16'hAAAA;
        tick();
        wtaddr = 10'd1023;
        tick();
        wtaddr = 10'd24;
        wtdina = 16'hFFFF;
        tick();
        wtdina = 16'h0BAD;
        tick();
        tick();
        wtaddr = '0;
        tick();
        check("sparse_wr_count", 32'(wr_count), 1);
        n = 0;
        while (!le && n < FRAME_CYC + 100) begin
            tick();
            n++;
        end
        check("sparse_shift_cycles", 32'(n), 32'(FRAME_CYC));
        check("sparse_sclk_rises", 32'(rise_cnt), 5760);
        for (int i = 0; i < N_LED; i++) begin
            check($sformatf("sparse_word%0d", i), 32'(words[i]), (i == 23) ? 32'hFFFF : 32'h0);
        end
        m = 0;
        while (le && m < 10) begin
            tick();
            m++;
        end
        check("sparse_le_cycles", 32'(m), 4);
        check("sparse_frame_done", 32'(frame_done), 1);
        check("sparse_overrun", 32'(overrun), 0);
        tick();
        check("sparse_done_pulse", 32'(frame_done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
